// File: rtl/dff_ctrl_pkg.sv
// Shared types and constants for the flip-flop bank load controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dff_ctrl_pkg;

    // Controller states; ST_PAR is only reachable when DFF_LOAD_CTRL_PARITY_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_PAR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Default word width, equal to the number of bank flip-flops sequenced
    localparam int DFF_WORD_W = 8;

    // ceil(log2(n)); used to size the bit-index counter
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_load_cnt.sv
// Bit-index counter with one-hot decode for sequencing the bank flip-flops.
// Latency: index updates one cycle after inc; one-hot and last decode straight from the index.
// Backpressure: none; clr has priority over inc, and the index saturates at N-1.
module dff_load_cnt
    import dff_ctrl_pkg::*;
#(
    parameter  int N  = DFF_WORD_W,
    localparam int KW = clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_clear_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [KW-1:0] o_k,
    output logic [N-1:0]  o_en,
    output logic          o_last
);

    logic [KW-1:0] r_k;
    logic [N-1:0]  w_one;

    assign w_one  = {{(N-1){1'b0}}, 1'b1};
    assign o_k    = r_k;
    assign o_en   = w_one << r_k;
    assign o_last = (r_k == KW'(N - 1));

    // Index restarts on clr and advances on inc, holding at N-1 so it never wraps
    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_k <= '0;
        end else if (i_clr) begin
            r_k <= '0;
        end else if (i_inc && !o_last) begin
            r_k <= r_k + KW'(1);
        end
    end

endmodule

// File: rtl/dff_load_ctrl.sv
// Serial-to-bank load sequencer: clear strobe, one-hot bit enables, parallel copy, done pulse.
// Latency: start to done is N+2 cycles (N+3 with DFF_LOAD_CTRL_PARITY_EN, which adds a parity-check state).
// Backpressure: start is only sampled in idle and never queued; abort drops the load from any active state except done.
module dff_load_ctrl
    import dff_ctrl_pkg::*;
#(
    parameter int N = DFF_WORD_W
) (
    input  logic         i_clk,
    input  logic         i_clear_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_sdata,
    output logic         o_busy,
    output logic         o_bank_clr,
    output logic [N-1:0] o_en,
    output logic         o_d,
    output logic [N-1:0] o_par_q,
    output logic         o_done,
    output logic         o_par_err
);

    localparam int KW = clog2(N);

    state_t        r_state;
    logic          r_busy;
    logic          r_bank_clr;
    logic          r_done;
    logic [N-1:0]  r_par_q;

    logic          w_load;
    logic          w_last;
    logic [KW-1:0] w_k;
    logic [N-1:0]  w_en_oh;

    assign w_load = (r_state == ST_LOAD);

    // The index only runs while loading; any other state parks it at zero
    dff_load_cnt #(
        .N (N)
    ) u_cnt (
        .i_clk     (i_clk),
        .i_clear_n (i_clear_n),
        .i_clr     (!w_load),
        .i_inc     (w_load),
        .o_k       (w_k),
        .o_en      (w_en_oh),
        .o_last    (w_last)
    );

    assign o_busy     = r_busy;
    assign o_bank_clr = r_bank_clr;
    assign o_done     = r_done;
    assign o_par_q    = r_par_q;
    // Bank enable and data are decoded from the state register; sdata is the only input passed through
    assign o_en       = w_en_oh & {N{w_load}};
    assign o_d        = w_load & i_sdata;

`ifdef DFF_LOAD_CTRL_PARITY_EN
    logic r_par_err;
    assign o_par_err = r_par_err;
`else
    assign o_par_err = 1'b0;
`endif

    // Sequencer: state transitions, registered status outputs and the parallel word copy
    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_bank_clr <= 1'b0;
            r_done     <= 1'b0;
            r_par_q    <= '0;
`ifdef DFF_LOAD_CTRL_PARITY_EN
            r_par_err  <= 1'b0;
`endif
        end else begin
            // Strobes and the error flag are single-cycle unless a branch re-asserts them
            r_bank_clr <= 1'b0;
            r_done     <= 1'b0;
`ifdef DFF_LOAD_CTRL_PARITY_EN
            r_par_err  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // abort is deliberately not looked at here, so start always wins
                    if (i_start) begin
                        r_state    <= ST_CLR;
                        r_busy     <= 1'b1;
                        r_bank_clr <= 1'b1;
                        r_par_q    <= '0;
                    end
                end
                ST_CLR: begin
                    r_par_q <= '0;
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (i_abort) begin
                        // No partial word survives a cancelled load
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_par_q <= '0;
                    end else begin
                        r_par_q[w_k] <= i_sdata;
                        if (w_last) begin
`ifdef DFF_LOAD_CTRL_PARITY_EN
                            r_state <= ST_PAR;
`else
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef DFF_LOAD_CTRL_PARITY_EN
                ST_PAR: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_par_q <= '0;
                    end else begin
                        // Even parity: the word plus its parity bit must XOR to zero
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_par_err <= (^r_par_q) ^ i_sdata;
                    end
                end
`endif
                ST_DONE: begin
                    // abort is ignored so the done pulse always completes
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
